mem_write_ctrl: RTL

- Parametrised, clocked successor to the combinational host-to-waveform-memory write path of the arbitrary function generator.
- Buffers host write requests in a small FIFO and generates timed external memory write cycles with programmable setup, pulse and hold lengths.
- Adds an auto-increment address mode for streaming waveform samples.
- Sits between the host bus interface and the external sample SRAM/flash.

---
 rtl/mem_write_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_write_ctrl.sv
// Host-to-waveform-memory write controller: queues host write requests in a small
// FIFO and replays them as timed setup / strobe / hold cycles on the external memory.
module mem_write_ctrl #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          CS,
    input  logic                          Write,
    input  logic [ADDR_W-1:0]             Addr_in,
    input  logic [DATA_W-1:0]             DataBus,
    input  logic                          Auto_inc,
    input  logic                          Addr_load,
    input  logic                          Ovf_clr,
    output logic [ADDR_W-1:0]             Addr_out,
    output logic [DATA_W-1:0]             Dout,
    output logic                          Mem_cs_n,
    output logic                          Write_out,
    output logic                          Busy,
    output logic                          Full,
    output logic [$clog2(FIFO_DEPTH):0]   Level,
    output logic                          Ovf
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [ADDR_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d;
    logic              cs_n_q, cs_n_d;
    logic              we_n_q, we_n_d;

    logic              req, full, push, pop, start_xfer, cnt_done;
    logic [ADDR_W-1:0] push_addr;

    assign cnt_done = (cnt_q == '0);

    // Request acceptance, address selection and overflow tracking.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path infers a latch.
        req       = ~CS & ~Write;
        full      = (level_q == LVL_W'(FIFO_DEPTH));
        push      = req & ~full;
        push_addr = (Auto_inc && !Addr_load) ? ptr_q : Addr_in;
        ptr_d     = ptr_q;
        if (push && Auto_inc) begin
            ptr_d = push_addr + ADDR_W'(1);
        end else if (Addr_load) begin
            ptr_d = Addr_in;
        end
        ovf_d = ovf_q;
        if (Ovf_clr) ovf_d = 1'b0;
        if (req && full) ovf_d = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cs_n_d     = cs_n_q;
        we_n_d     = we_n_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        start_xfer = 1'b0;
        case (state_q)
            ST_IDLE: start_xfer = (level_q != '0);
            ST_SETUP: begin
                if (cnt_done) begin
                    state_d = ST_PULSE;
                    we_n_d  = 1'b0;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_done) begin
                    state_d = ST_HOLD;
                    we_n_d  = 1'b1;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (level_q != '0) begin
                    start_xfer = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Back-to-back transfers keep chip select low straight from HOLD into SETUP.
        if (start_xfer) begin
            state_d          = ST_SETUP;
            cnt_d            = CNT_W'(SETUP_CYC - 1);
            cs_n_d           = 1'b0;
            {addr_d, dout_d} = fifo_mem[rd_ptr_q];
        end
        pop = start_xfer;
    end

    assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    assign level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking <= so every flop samples pre-edge values.
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ptr_q    <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            cs_n_q   <= cs_n_d;
            we_n_q   <= we_n_d;
        end
    end

    // NOTE: FIFO storage is left unreset on purpose; level_q guards every read of it.
    always_ff @(posedge Clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {push_addr, DataBus};
    end

    assign Addr_out  = addr_q;
    assign Dout      = dout_q;
    assign Mem_cs_n  = cs_n_q;
    assign Write_out = we_n_q;
    assign Busy      = (state_q != ST_IDLE) | (level_q != '0);
    assign Full      = full;
    assign Level     = level_q;
    assign Ovf       = ovf_q;
endmodule
